rxstr: RTL and testbench

UART receiver that deserializes 8N1 characters from the `rx` line into parallel bytes. It is the receiving end of the link driven by the codebase's `txstr` / `uart_tx` transmitters, and shares their `BAUDRATE` divisor convention (clock ticks per bit, from `baudgen.vh`). Each valid byte is presented on `data` with a one-cycle `rcv` strobe. Bad stop bits are flagged on `ferr`.

---
 rtl/rxstr.sv | 150 +++++++++++++++
 tb/tb_rxstr.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rxstr.sv
// 8N1 UART receiver: samples each bit at mid-bit using a BAUDRATE-tick down-counter,
// presents good bytes with a one-cycle rcv strobe and flags bad stop bits on ferr.
module rxstr #(
  parameter int unsigned BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr
);

  localparam int unsigned CW = $clog2(BAUDRATE);
  localparam int unsigned H  = BAUDRATE / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUDRATE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      data_q, data_d;
  logic            rcv_q, rcv_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sr_q     <= '0;
      data_q   <= '0;
      rcv_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      data_q   <= data_d;
      rcv_q    <= rcv_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    data_d   = data_q;
    rcv_d    = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end

      // Mid start bit: a line already back high was only a glitch.
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d  = S_DATA;
            cnt_d    = CNT_FULL;
            bitcnt_d = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          sr_d     = {rx_s_q, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          cnt_d    = CNT_FULL;
          if (bitcnt_q == 4'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            data_d  = sr_q;
            rcv_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Hold off until the line returns high so a stuck-low line errors only once.
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data = data_q;
  assign rcv  = rcv_q;
  assign ferr = ferr_q;

endmodule

// File: tb/tb_rxstr.sv
// Bench for rxstr: bit-exact serial line driver plus an expected-event queue
// derived from the frames sent (byte, outcome and strobe cycle).
module tb_rxstr;

  localparam int unsigned BAUD = 16;
  localparam int unsigned H    = BAUD / 2;
  // Cycle stamp of the strobe, relative to the cycle the start bit is driven.
  localparam int LAT = 1 + 2 + H + 9 * BAUD + 1 - 1;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         t;
    logic       good;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         gap;
    logic       exp_good;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  rxstr #(.BAUDRATE(BAUD)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Hold the line at v for n clock periods; returns just after a rising edge.
  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_event(input logic good, input logic [7:0] b);
    exp_t e;
    e.t    = cyc + LAT;
    e.good = good;
    e.d    = good ? b : last_good;
    if (good) last_good = b;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic exp_good);
    expect_event(exp_good, b);
    line(1'b0, BAUD);
    for (int i = 0; i < 8; i++) line(b[i], BAUD);
    line(stop, BAUD);
  endtask

  // Every strobe must match the head of the expectation queue in kind, cycle and byte.
  always @(negedge clk) begin
    if (!rst && (rcv || ferr)) begin
      chk("exclusive_rcv_ferr", int'(rcv & ferr), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", int'({rcv, ferr}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_kind_rcv", int'(rcv), int'(e.good));
        chk("strobe_cycle", cyc, e.t);
        chk("data_on_strobe", int'(data), int'(e.d));
      end
    end
  end

  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'h48, 1'b1, 20, 1'b1};
    tbl[1] = '{8'h48, 1'b1,  0, 1'b1};
    tbl[2] = '{8'h65, 1'b1,  0, 1'b1};
    tbl[3] = '{8'h6C, 1'b1,  0, 1'b1};
    tbl[4] = '{8'h6C, 1'b1,  0, 1'b1};
    tbl[5] = '{8'h6F, 1'b1,  0, 1'b1};
    tbl[6] = '{8'h21, 1'b1, 12, 1'b1};
    tbl[7] = '{8'hA5, 1'b0, 20, 1'b0};
    tbl[8] = '{8'h3C, 1'b1, 10, 1'b1};
    tbl[9] = '{8'h00, 1'b1,  5, 1'b1};

    rst = 1'b0;
    rx  = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset_data", int'(data), 0);
    chk("reset_rcv", int'(rcv), 0);
    chk("reset_ferr", int'(ferr), 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    line(1'b1, 10);

    // Single byte, "Hello!" back-to-back, framing error then recovery.
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, tbl[i].exp_good);
      line(1'b1, tbl[i].gap);
    end

    // Short low glitch: no strobe, then a clean byte.
    line(1'b0, 4);
    line(1'b1, 30);
    send_frame(8'h3C, 1'b1, 1'b1);
    line(1'b1, 10);

    // Line held low for three frame times: one ferr only.
    expect_event(1'b0, 8'h00);
    line(1'b0, 3 * 10 * BAUD);
    line(1'b1, 20);
    send_frame(8'h55, 1'b1, 1'b1);
    line(1'b1, 10);

    // Reset during data bit 4 of 0xFF: frame discarded, outputs cleared.
    line(1'b0, BAUD);
    line(1'b1, 4 * BAUD + H);
    #2 rst = 1'b1;
    #1;
    chk("midframe_reset_data", int'(data), 0);
    chk("midframe_reset_rcv", int'(rcv), 0);
    chk("midframe_reset_ferr", int'(ferr), 0);
    last_good = 8'h00;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    line(1'b1, 4 * BAUD + 40);
    chk("after_reset_data", int'(data), 0);
    send_frame(8'h81, 1'b1, 1'b1);
    line(1'b1, 10);

    // Random frames, random stop bits and idle gaps.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 12));
      send_frame(b, stop, stop);
      line(1'b1, gap);
    end

    line(1'b1, 40);
    chk("held_data", int'(data), int'(last_good));
    chk("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
